// File: rtl/draw_num_multi.sv
// Seven-segment decimal overlay: converts value to BCD (double-dabble, VAL_W+1 busy cycles per frame)
// and renders DIGITS cells; render pipe is 2 cycles, runs every cycle, and has no backpressure.
module draw_num_multi #(
    parameter int DIGITS = 5,
    parameter int VAL_W  = 20,
    parameter int SEG_T  = 4,
    parameter int SEG_W  = 14,
    parameter int SEG_H  = 44,
    parameter int GAP    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] value,
    input  logic             frame_start,
    input  logic             enable,
    input  logic [10:0]      x,
    input  logic [9:0]       y,
    input  logic [10:0]      countx,
    input  logic [9:0]       county,
    output logic             check,
    output logic             busy,
    output logic             overflow
);

    localparam int BW    = 4 * DIGITS;
    localparam int CW    = $clog2(VAL_W + 1);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PITCH = SEG_W + GAP;
    localparam int MID   = (SEG_H - SEG_T) / 2;

    function automatic logic [63:0] max_val(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAXV = max_val(DIGITS);

    function automatic logic [6:0] seg_dec(input logic [3:0] n);
        case (n)                       // bit order {a,b,c,d,e,f,g}
            4'd0:    seg_dec = 7'b1111110;
            4'd1:    seg_dec = 7'b0110000;
            4'd2:    seg_dec = 7'b1101101;
            4'd3:    seg_dec = 7'b1111001;
            4'd4:    seg_dec = 7'b0110011;
            4'd5:    seg_dec = 7'b1011011;
            4'd6:    seg_dec = 7'b1011111;
            4'd7:    seg_dec = 7'b1110000;
            4'd8:    seg_dec = 7'b1111111;
            4'd9:    seg_dec = 7'b1111011;
            default: seg_dec = 7'b0000000;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t           state;
    logic [VAL_W-1:0] bin;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    disp;
    logic [CW-1:0]    cnt;
    logic             ovf_pend;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bin      <= '0;
            bcd      <= '0;
            disp     <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        bin      <= value;
                        bcd      <= '0;
                        cnt      <= CW'(VAL_W);
                        ovf_pend <= 64'(value) > MAXV;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {bcd_adj[BW-2:0], bin, 1'b0};
                    cnt        <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= COMMIT;
                end
                COMMIT: begin
                    // Saturated display is all nines; the truncated BCD is meaningless then.
                    disp     <= ovf_pend ? {DIGITS{4'h9}} : bcd;
                    overflow <= ovf_pend;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [3:0]        dig    [DIGITS];
    logic [11:0]       cell_lx[DIGITS];
    logic [DIGITS-1:0] cell_in;
    logic [12:0]       dy;

    assign dy = {3'b000, county} - {3'b000, y};

    // Bit 12 of each difference is the borrow, so cells off the right/bottom edge never match.
    for (genvar k = 0; k < DIGITS; k++) begin : g_cell
        logic [12:0] dx;
        assign dx         = {2'b00, countx} - ({2'b00, x} + 13'(k * PITCH));
        assign cell_in[k] = !dx[12] && !dy[12] && (dx[11:0] < 12'(SEG_W)) && (dy[11:0] < 12'(SEG_H));
        assign cell_lx[k] = dx[11:0];
        assign dig[k]     = disp[4*(DIGITS-1-k) +: 4];
    end

    logic [IW-1:0] idx_c;
    logic [11:0]   lx_c;

    always_comb begin
        idx_c = '0;
        lx_c  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (cell_in[k]) begin
                idx_c = IW'(k);
                lx_c  = cell_lx[k];
            end
        end
    end

    logic          in1;
    logic [IW-1:0] idx1;
    logic [11:0]   lx1;
    logic [11:0]   ly1;

    always_ff @(posedge clk) begin
        if (reset) begin
            in1  <= 1'b0;
            idx1 <= '0;
            lx1  <= '0;
            ly1  <= '0;
        end else begin
            in1  <= enable && (|cell_in);
            idx1 <= idx_c;
            lx1  <= lx_c;
            ly1  <= dy[11:0];
        end
    end

    logic [DIGITS-1:0] lz;
    logic              zrun;
    logic [3:0]        nib;
    logic              blank;
    logic [6:0]        geo;

    always_comb begin
        zrun = 1'b1;
        lz   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            zrun  = zrun && (dig[k] == 4'd0);
            lz[k] = zrun && (k != DIGITS - 1);
        end
        nib   = 4'd0;
        blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx1 == IW'(k)) begin
                nib   = dig[k];
                blank = lz[k];
            end
        end
        geo[6] = ly1 < 12'(SEG_T);
        geo[5] = (lx1 >= 12'(SEG_W - SEG_T)) && (ly1 < 12'(MID + SEG_T));
        geo[4] = (lx1 >= 12'(SEG_W - SEG_T)) && (ly1 >= 12'(MID));
        geo[3] = ly1 >= 12'(SEG_H - SEG_T);
        geo[2] = (lx1 < 12'(SEG_T)) && (ly1 >= 12'(MID));
        geo[1] = (lx1 < 12'(SEG_T)) && (ly1 < 12'(MID + SEG_T));
        geo[0] = (ly1 >= 12'(MID)) && (ly1 < 12'(MID + SEG_T));
    end

    always_ff @(posedge clk) begin
        if (reset) check <= 1'b0;
        else       check <= in1 && !blank && (|(seg_dec(nib) & geo));
    end

endmodule

// File: tb/tb_draw_num_multi.sv
// Directed bench for draw_num_multi: point probes and window scans with hand-computed pixel counts.
module tb_draw_num_multi;

    logic        clk;
    logic        reset;
    logic [19:0] value;
    logic        frame_start;
    logic        enable;
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] countx;
    logic [9:0]  county;
    logic        check;
    logic        busy;
    logic        overflow;

    int vecs;
    int errs;

    draw_num_multi dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .frame_start(frame_start),
        .enable     (enable),
        .x          (x),
        .y          (y),
        .countx     (countx),
        .county     (county),
        .check      (check),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input string tag, input int px, input int py, input logic exp);
        @(negedge clk);
        countx = 11'(px);
        county = 10'(py);
        @(negedge clk);
        @(negedge clk);
        chk(tag, {31'b0, check}, {31'b0, exp});
    endtask

    task automatic kick(input logic [19:0] v);
        @(negedge clk);
        value       = v;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic run(input logic [19:0] v, output int n);
        kick(v);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy !== 1'b1) break;
            n++;
            @(negedge clk);
        end
    endtask

    // Streams a window; result for the pixel driven two negedges ago is read first.
    task automatic scan(input int x0, input int y0, input int w, input int h,
                        input int bx0, input int bx1, output int lit, output int outside);
        int n;
        int j;
        int px;
        n       = w * h;
        lit     = 0;
        outside = 0;
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                j  = i - 2;
                px = x0 + (j % w);
                if (check === 1'b1) begin
                    lit++;
                    if (px < bx0 || px > bx1) outside++;
                end
            end
            if (i < n) begin
                countx = 11'(x0 + (i % w));
                county = 10'(y0 + (i / w));
            end
        end
    endtask

    initial begin
        int n;
        int lit;
        int outside;
        vecs        = 0;
        errs        = 0;
        reset       = 1'b1;
        value       = '0;
        frame_start = 1'b0;
        enable      = 1'b1;
        x           = 11'd100;
        y           = 10'd50;
        countx      = '0;
        county      = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_ovf", {31'b0, overflow}, 0);
        chk("rst_check", {31'b0, check}, 0);
        reset = 1'b0;

        // Reset display is a single "0" in the rightmost cell (cx=180).
        scan(100, 50, 200, 60, 180, 193, lit, outside);
        chk("zero_lit", lit, 400);
        chk("zero_outside", outside, 0);
        chk("zero_ovf", {31'b0, overflow}, 0);

        run(20'd12345, n);
        chk("busy_12345", n, 21);
        pix("d0_seg_a_12345", 100, 50, 1'b0);
        pix("d0_seg_b_12345", 112, 60, 1'b1);
        pix("d1_seg_a_12345", 120, 50, 1'b1);
        pix("d4_seg_c_12345", 193, 80, 1'b1);
        pix("d4_seg_e_12345", 180, 80, 1'b0);
        chk("ovf_12345", {31'b0, overflow}, 0);

        run(20'd7, n);
        chk("busy_7", n, 21);
        pix("blank_d0_7", 100, 50, 1'b0);
        pix("d4_seg_a_7", 180, 50, 1'b1);
        pix("d4_seg_b_7", 192, 60, 1'b1);
        pix("d4_g_row_7", 180, 70, 1'b0);
        pix("d4_seg_d_7", 185, 90, 1'b0);
        scan(100, 50, 200, 60, 180, 193, lit, outside);
        chk("seven_lit", lit, 216);
        chk("seven_outside", outside, 0);

        run(20'd100000, n);
        chk("ovf_set", {31'b0, overflow}, 1);
        pix("sat_d0_a", 100, 50, 1'b1);
        pix("sat_d0_e", 100, 80, 1'b0);
        run(20'd99999, n);
        chk("ovf_clear", {31'b0, overflow}, 0);
        pix("n99999_d0_a", 100, 50, 1'b1);

        // Second frame_start at cycle 5 of a conversion must be dropped entirely.
        kick(20'd42);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy === 1'b1) n++;
            if (i == 4) value = 20'd888;
            frame_start = (i == 4);
            @(negedge clk);
        end
        chk("busy_ignore", n, 21);
        chk("idle_after_ignore", {31'b0, busy}, 0);
        pix("d3_seg_a_42", 165, 50, 1'b0);
        pix("d3_seg_f_42", 160, 60, 1'b1);
        pix("d4_seg_c_42", 193, 80, 1'b0);
        pix("blank_d2_42", 140, 50, 1'b0);

        run(20'd100000, n);
        chk("ovf_before_rst", {31'b0, overflow}, 1);
        kick(20'd888);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_ovf", {31'b0, overflow}, 0);
        pix("abort_d4_c", 193, 80, 1'b1);
        pix("abort_d4_a", 185, 50, 1'b1);
        pix("abort_d3_blank", 165, 50, 1'b0);

        run(20'd88888, n);
        chk("busy_88888", n, 21);
        x = 11'd2040;
        y = 10'd0;
        scan(2030, 0, 18, 50, 2040, 2047, lit, outside);
        chk("edge_lit", lit, 224);
        chk("edge_outside", outside, 0);
        scan(0, 0, 11, 50, 0, 10, lit, outside);
        chk("no_wrap", lit, 0);

        x      = 11'd100;
        y      = 10'd50;
        enable = 1'b0;
        scan(100, 50, 200, 60, 100, 193, lit, outside);
        chk("enable_off", lit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
